// File: rtl/popcount_seq_ctrl_if.sv
// Producer/consumer handshake bundle for the sequential popcount block.
// master = testbench/producer+consumer side, slave = the counting block.
interface popcount_seq_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_zeros;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_zeros, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, in_zeros, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Sequential popcount: a latched word is shifted through one 7-bit popcount
// per cycle and the 3-bit partial counts are summed into an accumulator.
// Clear-bit counting inverts the word on accept; pad bits stay zero.
module popcount_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  popcount_seq_ctrl_if.slave bus,
  output logic               busy
);
  localparam int CHUNK_W = 7;
  localparam int NCHUNK  = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W   = NCHUNK * CHUNK_W;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [PAD_W-1:0]   word, word_ld;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   acc;
  logic [CNT_W-1:0]   pc_ext;
  logic               accept;
  logic               last;

  // 7-input popcount; result is at most 7 so 3 bits suffice.
  function automatic logic [2:0] pc7(input logic [CHUNK_W-1:0] c);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < CHUNK_W; i++) s = s + {2'b00, c[i]};
    return s;
  endfunction

  // Padded load value: pad bits are zero whether counting ones or zeros.
  always_comb begin
    word_ld = '0;
    word_ld[DATA_W-1:0] = bus.in_zeros ? ~bus.in_data : bus.in_data;
  end

  // Chunk count never exceeds DATA_W, so truncation to CNT_W is lossless.
  assign pc_ext = CNT_W'(pc7(word[CHUNK_W-1:0]));
  assign last   = (idx == IDX_W'(NCHUNK - 1));
  assign bus.out_count = acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake outputs; DONE forwards out_ready to in_ready
  // so a new word can be taken in the same cycle the result leaves.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept   = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load on accept, otherwise shift one chunk out per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      acc  <= '0;
      idx  <= '0;
    end else if (accept) begin
      word <= word_ld;
      acc  <= '0;
      idx  <= '0;
    end else if (state == RUN) begin
      word <= word >> CHUNK_W;
      acc  <= acc + pc_ext;
      idx  <= last ? '0 : idx + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Scoreboard bench: the driver pushes the reference count on every accept,
// a negedge monitor pops and compares on every output handshake.
module tb_popcount_seq_ctrl;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  popcount_seq_ctrl_if #(.DATA_W(DATA_W)) bus ();

  popcount_seq_ctrl #(.DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_hs = 0;
  int hs_cyc[$];
  int sb[$];
  bit ready_rand = 1'b0;
  bit ready_val  = 1'b1;
  bit acc_in_done;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: count of bits equal to the selected polarity over DATA_W bits.
  function automatic int ref_count(input logic [DATA_W-1:0] w, input bit z);
    int ones;
    ones = $countones(w);
    return z ? (DATA_W - ones) : ones;
  endfunction

  // Consumer ready: random or directed, updated just after each edge.
  always @(posedge clk) begin
    #2;
    bus.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
  end

  // Monitor: a result is consumed when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_hs++;
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else chk("out_count", int'(bus.out_count), sb.pop_front());
    end
  end

  // Present a word until accepted; optionally leave in_valid high afterwards.
  task automatic send(input logic [DATA_W-1:0] w, input bit z, input bit hold);
    bus.in_data  = w;
    bus.in_zeros = z;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(ref_count(w, z));
        acc_in_done = bus.out_valid;
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int lat, hs0, b0;
    bit z;
    logic [DATA_W-1:0] w;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_zeros  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // All ones: latency 5, then back to IDLE
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("latency", lat, 5);
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;

    // Polarity and padding
    send(32'h0000_0000, 1'b1, 1'b0); drain();
    send(32'h8000_0001, 1'b0, 1'b0); drain();
    send(32'h8000_0001, 1'b1, 1'b0); drain();

    // Backpressure: result held for 10 cycles, then exactly one handshake
    ready_val = 1'b0;
    @(posedge clk); #1;
    send(32'h0F0F_0F0F, 1'b0, 1'b0);
    for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_count", bus.out_count, 16);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    hs0 = n_hs;
    @(posedge clk); #1;
    ready_val = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_one_handshake", n_hs - hs0, 1);
    chk("bp_sb_empty", sb.size(), 0);

    // Back-to-back with accept in DONE
    b0 = hs_cyc.size();
    send(32'h1, 1'b0, 1'b1);
    send(32'h3, 1'b0, 1'b1);
    chk("b2b_accept_in_done1", acc_in_done, 1);
    send(32'h7, 1'b0, 1'b0);
    chk("b2b_accept_in_done2", acc_in_done, 1);
    drain();
    chk("b2b_results", hs_cyc.size() - b0, 3);
    if (hs_cyc.size() - b0 == 3) begin
      chk("b2b_spacing1", hs_cyc[b0+1] - hs_cyc[b0], 6);
      chk("b2b_spacing2", hs_cyc[b0+2] - hs_cyc[b0+1], 6);
    end

    // Reset mid-RUN at idx 2
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_count", bus.out_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    hs0 = n_hs;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_result", n_hs - hs0, 0);
    send(32'hAAAA_AAAA, 1'b0, 1'b0);
    drain();

    // Random traffic with random gaps on both sides
    ready_rand = 1'b1;
    hs0 = n_hs;
    for (int k = 0; k < 1000; k++) begin
      w = $urandom();
      z = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: w = '0;
        1: w = '1;
        default: ;
      endcase
      send(w, z, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if (cyc > 90000) break;
    end
    drain();
    chk("rand_result_count", n_hs - hs0, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
